// File: rtl/seq111_frame_arbiter.sv
// seq111_frame_arbiter: round-robin arbiter that lends a single overlapping
// "111" detector to NUM_REQ serial requesters, one frame of FRAME_LEN bits
// at a time, and reports the match count and requester id per frame.
//
// Handshake: bit_rdy is high for the whole RUN state; a bit of the granted
// requester is transferred on a rising edge where bit_rdy & bit_vld[granted]
// are both 1. Bits and valids of other requesters are ignored. Stalls
// (bit_vld low) never disturb the detector run state or the bit index.
module seq111_frame_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 5,
  localparam int ID_W     = $clog2(NUM_REQ),
  localparam int IDX_W    = $clog2(FRAME_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] bit_in,
  input  logic [NUM_REQ-1:0] bit_vld,
  output logic [NUM_REQ-1:0] grant,
  output logic               bit_rdy,
  output logic               det,
  output logic               done,
  output logic               abort,
  output logic [ID_W-1:0]    done_id,
  output logic [CNT_W-1:0]   match_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [ID_W-1:0]    gid_q;
  logic [ID_W-1:0]    rr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [1:0]         run_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               bit_rdy_q;
  logic               det_q;
  logic               done_q;
  logic               abort_q;
  logic [ID_W-1:0]    done_id_q;
  logic [CNT_W-1:0]   match_cnt_q;

  logic               pick_vld;
  logic [ID_W-1:0]    pick_id;
  logic               acc;
  logic               cur_bit;
  logic               last_bit;
  logic               hit;
  logic [1:0]         run_d;

  // Round-robin pick: first asserted req strictly after rr_q, wrapping around.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int c;
      c = int'(rr_q) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!pick_vld && req[c]) begin
        pick_vld = 1'b1;
        pick_id  = ID_W'(c);
      end
    end
  end

  // Datapath terms for the bit offered by the granted requester this cycle.
  always_comb begin
    acc      = (state_q == RUN) && bit_vld[gid_q];
    cur_bit  = bit_in[gid_q];
    last_bit = (idx_q == IDX_W'(FRAME_LEN - 1));
    hit      = cur_bit && (run_q == 2'd2);
    run_d    = cur_bit ? ((run_q == 2'd2) ? 2'd2 : run_q + 2'd1) : 2'd0;
  end

  // Frame FSM with registered grant/status outputs and per-frame counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gid_q       <= '0;
      rr_q        <= ID_W'(NUM_REQ - 1);
      idx_q       <= '0;
      run_q       <= '0;
      grant_q     <= '0;
      bit_rdy_q   <= 1'b0;
      det_q       <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      done_id_q   <= '0;
      match_cnt_q <= '0;
    end else begin
      det_q   <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            state_q     <= RUN;
            gid_q       <= pick_id;
            grant_q     <= NUM_REQ'(1) << pick_id;
            bit_rdy_q   <= 1'b1;
            idx_q       <= '0;
            run_q       <= '0;
            match_cnt_q <= '0;
          end
        end
        RUN: begin
          if (acc && last_bit) begin
            // Final bit wins over a same-edge req drop: the frame completes.
            det_q       <= hit;
            match_cnt_q <= match_cnt_q + CNT_W'(hit);
            run_q       <= run_d;
            idx_q       <= idx_q + IDX_W'(1);
            state_q     <= DONE;
            done_q      <= 1'b1;
            done_id_q   <= gid_q;
            grant_q     <= '0;
            bit_rdy_q   <= 1'b0;
            rr_q        <= gid_q;
          end else if (!req[gid_q]) begin
            // Requester gave up mid-frame; partial count stays visible.
            state_q   <= IDLE;
            abort_q   <= 1'b1;
            done_id_q <= gid_q;
            grant_q   <= '0;
            bit_rdy_q <= 1'b0;
            rr_q      <= gid_q;
          end else if (acc) begin
            det_q       <= hit;
            match_cnt_q <= match_cnt_q + CNT_W'(hit);
            run_q       <= run_d;
            idx_q       <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant     = grant_q;
  assign bit_rdy   = bit_rdy_q;
  assign det       = det_q;
  assign done      = done_q;
  assign abort     = abort_q;
  assign done_id   = done_id_q;
  assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_seq111_frame_arbiter.sv
// Directed bench for seq111_frame_arbiter: frame results are predicted by a
// small "111" model when bits are driven and checked when done/abort pulses.
module tb_seq111_frame_arbiter;

  localparam int NR = 4;
  localparam int FL = 16;

  logic          clk;
  logic          rst;
  logic [NR-1:0] req;
  logic [NR-1:0] bit_in;
  logic [NR-1:0] bit_vld;
  logic [NR-1:0] grant;
  logic          bit_rdy;
  logic          det;
  logic          done;
  logic          abort;
  logic [1:0]    done_id;
  logic [4:0]    match_cnt;

  logic [7:0] exp_q[$];   // {abort, id[1:0], count[4:0]}
  int n_total = 0;
  int n_pass  = 0;
  int m_run;
  int m_cnt;

  seq111_frame_arbiter #(.NUM_REQ(NR), .FRAME_LEN(FL), .CNT_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .bit_in   (bit_in),
    .bit_vld  (bit_vld),
    .grant    (grant),
    .bit_rdy  (bit_rdy),
    .det      (det),
    .done     (done),
    .abort    (abort),
    .done_id  (done_id),
    .match_cnt(match_cnt)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard: every done/abort pulse must match the oldest prediction.
  always @(negedge clk) begin
    if (done || abort) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, done, abort}, 32'd0);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("frame_result", {24'd0, abort, done_id, match_cnt}, {24'd0, e});
      end
    end
  end

  // Drive one cycle of requester id and advance the reference model.
  task automatic step(input int id, input logic b, input logic v, output logic e);
    bit_vld = '0;
    bit_in  = '0;
    bit_vld[id] = v;
    bit_in[id]  = b;
    e = v && b && (m_run == 2);
    if (v) begin
      m_run = b ? ((m_run == 2) ? 2 : m_run + 1) : 0;
      if (e) m_cnt++;
    end
  endtask

  task automatic bit_cycle(input int id, input logic b, input logic v);
    logic e;
    step(id, b, v, e);
    @(negedge clk);
    chk("det", det, e);
  endtask

  task automatic wait_grant(input int id);
    int w;
    w = 0;
    while (grant !== NR'(1 << id) && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("grant_wait", grant, 1 << id);
    chk("cnt_clear", match_cnt, 0);
    m_run = 0;
    m_cnt = 0;
  endtask

  // Full frame, optional stall burst before bit stall_at, optional req drop on the last bit.
  task automatic run_frame(input int id, input logic [15:0] bits, input int stall_at,
                           input int stall_n, input bit drop_at_end);
    logic e;
    wait_grant(id);
    for (int i = 0; i < FL; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_n; s++) bit_cycle(id, 1'b1, 1'b0);
      end
      step(id, bits[FL-1-i], 1'b1, e);
      if (i == FL - 1) begin
        exp_q.push_back({1'b0, 2'(id), 5'(m_cnt)});
        if (drop_at_end) req[id] = 1'b0;
      end
      @(negedge clk);
      chk("det", det, e);
      if (i < FL - 1) begin
        chk("grant_run", grant, 1 << id);
      end else begin
        chk("done_pulse", done, 1);
        chk("grant_done", grant, 0);
      end
    end
    bit_vld = '0;
  endtask

  initial begin
    logic [15:0] v;
    logic e;
    rst = 1'b1; req = '0; bit_in = '0; bit_vld = '0;
    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_bit_rdy", bit_rdy, 0);
    chk("rst_det", det, 0);
    chk("rst_done", done, 0);
    chk("rst_abort", abort, 0);
    chk("rst_done_id", done_id, 0);
    chk("rst_match_cnt", match_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    // All ones: 14 overlapping matches, count held afterwards
    req[0] = 1'b1;
    run_frame(0, 16'hFFFF, -1, 0, 1);
    chk("t1_cnt", match_cnt, 14);
    chk("t1_id", done_id, 0);
    repeat (3) @(negedge clk);
    chk("t1_hold", match_cnt, 14);
    chk("t1_idle_grant", grant, 0);
    chk("t1_idle_rdy", bit_rdy, 0);

    // 0110 repeated: never three ones in a row
    req[0] = 1'b1;
    run_frame(0, 16'h6666, -1, 0, 1);
    chk("t2_cnt", match_cnt, 0);

    // 1,1,stall x3,1,0...: stalls do not break the run
    req[0] = 1'b1;
    run_frame(0, 16'hE000, 2, 3, 1);
    chk("t4_cnt", match_cnt, 1);

    // Frame A ends 1,1 and frame B starts 1,1,0: no match across frames
    req[0] = 1'b1;
    run_frame(0, 16'h0003, -1, 0, 0);
    run_frame(0, 16'hC000, -1, 0, 1);
    chk("t5_cnt", match_cnt, 0);
    @(negedge clk);

    // Round robin from reset with all requesters held
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = '1;
    for (int k = 0; k < 5; k++) begin
      v = 16'($urandom_range(0, 65535));
      run_frame(k % NR, v, -1, 0, 0);
    end
    req = '0;
    @(negedge clk);

    // Abort after 5 bits, next requester granted
    req[0] = 1'b1;
    wait_grant(0);
    bit_cycle(0, 1'b1, 1'b1);
    bit_cycle(0, 1'b1, 1'b1);
    bit_cycle(0, 1'b1, 1'b1);
    bit_cycle(0, 1'b1, 1'b1);
    bit_cycle(0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b0, e);
    req[0] = 1'b0;
    req[1] = 1'b1;
    exp_q.push_back({1'b1, 2'd0, 5'(m_cnt)});
    @(negedge clk);
    chk("t6_abort", abort, 1);
    chk("t6_abort_grant", grant, 0);
    chk("t6_abort_nodone", done, 0);
    chk("t6_partial_cnt", match_cnt, 2);
    @(negedge clk);
    chk("t6_next_grant", grant, 2);
    m_run = 0;
    m_cnt = 0;
    bit_cycle(1, 1'b1, 1'b1);
    bit_cycle(1, 1'b1, 1'b1);
    bit_cycle(1, 1'b1, 1'b1);

    // Reset mid-frame: everything clears, requester 0 regains priority
    rst = 1'b1;
    req = 4'b0011;
    bit_vld = '0;
    @(negedge clk);
    chk("t6_rst_grant", grant, 0);
    chk("t6_rst_rdy", bit_rdy, 0);
    chk("t6_rst_det", det, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_abort", abort, 0);
    chk("t6_rst_id", done_id, 0);
    chk("t6_rst_cnt", match_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_prio_grant", grant, 1);
    req = '0;
    exp_q.push_back({1'b1, 2'd0, 5'd0});
    @(negedge clk);
    chk("t6_final_abort", abort, 1);
    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
